bus_slave: RTL and testbench

//  Serial-bus target consuming frames driven by the bus master: 16-bit address, 4-cycle ACK window,

---
 rtl/bus_slave.sv | 175 +++++++++++++++++
 tb/tb_bus_slave.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_slave.sv
// Serial-bus target: LSB-first 16-bit address, ACK windows, 8-bit write/read data.
// Decodes SLAVE_ID from ADDR[15:12] and owns a MEM_DEPTH-byte local memory.
module bus_slave #(
    parameter logic [3:0] SLAVE_ID  = 4'h1,
    parameter int         MEM_DEPTH = 256
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic B_UTIL,
    input  logic B_RW,
    input  logic B_BUS_IN,
    output logic S_ACK,
    output logic S_BUS_OUT,
    output logic S_BSY
);

    localparam int unsigned AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [12:0] DEPTH_L = 13'(MEM_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_AACK,
        ST_WDATA,
        ST_WACK,
        ST_RDATA
    } state_t;

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic [15:0] addr, addr_d;
    logic        rw, rw_d;
    logic [7:0]  wd, wd_d;
    logic [7:0]  rd, rd_d;
    logic        ack_d, bus_out_d;
    logic        sel, sel_d;
    logic        mem_we;

    logic [7:0]  mem [MEM_DEPTH];

    assign sel   = (addr[15:12] == SLAVE_ID) && ({1'b0, addr[11:0]} < DEPTH_L);
    assign S_BSY = (state != ST_IDLE);

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        addr_d    = addr;
        rw_d      = rw;
        wd_d      = wd;
        rd_d      = rd;
        bus_out_d = 1'b0;
        mem_we    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (B_UTIL) begin
                    // Bit 0 is consumed here, so ADDR starts counting at 1.
                    addr_d[0] = B_BUS_IN;
                    cnt_d     = 4'd1;
                    state_d   = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (!B_UTIL) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    addr_d[cnt] = B_BUS_IN;
                    if (cnt == 4'd15) begin
                        rw_d    = B_RW;
                        cnt_d   = '0;
                        state_d = ST_AACK;
                    end else begin
                        cnt_d = cnt + 4'd1;
                    end
                end
            end

            ST_AACK: begin
                if (cnt == 4'd3) begin
                    cnt_d = '0;
                    if (!sel) begin
                        state_d = ST_IDLE;
                    end else if (rw) begin
                        state_d = ST_WDATA;
                    end else begin
                        rd_d    = mem[addr[AW-1:0]];
                        state_d = ST_RDATA;
                    end
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end

            ST_WDATA: begin
                if (!B_UTIL) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    wd_d[cnt[2:0]] = B_BUS_IN;
                    if (cnt == 4'd7) begin
                        cnt_d   = '0;
                        state_d = ST_WACK;
                    end else begin
                        cnt_d = cnt + 4'd1;
                    end
                end
            end

            ST_WACK: begin
                mem_we = (cnt == 4'd0);
                if (cnt == 4'd3) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end

            ST_RDATA: begin
                if (B_UTIL) begin
                    bus_out_d = rd[cnt[2:0]];
                    if (cnt == 4'd7) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt + 4'd1;
                    end
                end else begin
                    // Lost grant: restart the byte from bit 0 on resume.
                    cnt_d = '0;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // ACK is computed from the next state so it lines up with the window cycles.
        sel_d = (addr_d[15:12] == SLAVE_ID) && ({1'b0, addr_d[11:0]} < DEPTH_L);
        ack_d = (state_d == ST_WACK) || ((state_d == ST_AACK) && sel_d);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            addr      <= '0;
            rw        <= 1'b0;
            wd        <= '0;
            rd        <= '0;
            S_ACK     <= 1'b0;
            S_BUS_OUT <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            addr      <= addr_d;
            rw        <= rw_d;
            wd        <= wd_d;
            rd        <= rd_d;
            S_ACK     <= ack_d;
            S_BUS_OUT <= bus_out_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[addr[AW-1:0]] <= wd;
        end
    end

endmodule

// File: tb/tb_bus_slave.sv
// Directed testbench for bus_slave: drives LSB-first frames and checks ACK windows,
// read data bits, busy flag, decode boundaries, aborts and asynchronous reset.
module tb_bus_slave;

    logic CLK      = 1'b0;
    logic RSTN     = 1'b0;
    logic B_UTIL   = 1'b0;
    logic B_RW     = 1'b0;
    logic B_BUS_IN = 1'b0;
    logic S_ACK;
    logic S_BUS_OUT;
    logic S_BSY;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    bus_slave #(
        .SLAVE_ID (4'h1),
        .MEM_DEPTH(256)
    ) dut (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .B_UTIL   (B_UTIL),
        .B_RW     (B_RW),
        .B_BUS_IN (B_BUS_IN),
        .S_ACK    (S_ACK),
        .S_BUS_OUT(S_BUS_OUT),
        .S_BSY    (S_BSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives the first nbits address bits; the first one is sampled in IDLE.
    task automatic send_addr(input logic [15:0] a, input logic rw, input int nbits);
        B_UTIL = 1'b1;
        B_RW   = rw;
        for (int i = 0; i < nbits; i++) begin
            B_BUS_IN = a[i];
            tick();
        end
        check("addr_bsy", S_BSY, 1);
    endtask

    task automatic aack(input logic exp_sel);
        B_BUS_IN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("aack_ack", S_ACK, exp_sel);
            check("aack_bout", S_BUS_OUT, 0);
            tick();
        end
        if (!exp_sel) begin
            B_UTIL = 1'b0;
            check("unsel_idle_bsy", S_BSY, 0);
            check("unsel_idle_ack", S_ACK, 0);
        end
    endtask

    task automatic wphase(input logic [7:0] d, input bit keep);
        for (int i = 0; i < 8; i++) begin
            B_BUS_IN = d[i];
            check("wdata_ack", S_ACK, 0);
            check("wdata_bsy", S_BSY, 1);
            tick();
        end
        B_BUS_IN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("wack_ack", S_ACK, 1);
            tick();
        end
        if (!keep) B_UTIL = 1'b0;
        check("wack_done_bsy", S_BSY, 0);
        check("wack_done_ack", S_ACK, 0);
    endtask

    task automatic rphase(input logic [7:0] d, input bit keep);
        check("rdata_start", S_BUS_OUT, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rdata_bit", S_BUS_OUT, d[i]);
            check("rdata_bsy", S_BSY, (i != 7));
        end
        if (!keep) begin
            B_UTIL = 1'b0;
            tick();
            check("rdata_after", S_BUS_OUT, 0);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input bit keep);
        send_addr(a, 1'b1, 16);
        aack(1'b1);
        wphase(d, keep);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] d, input bit keep);
        send_addr(a, 1'b0, 16);
        aack(1'b1);
        rphase(d, keep);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        RSTN = 1'b0;
        repeat (3) tick();
        check("rst_ack", S_ACK, 0);
        check("rst_bout", S_BUS_OUT, 0);
        check("rst_bsy", S_BSY, 0);
        RSTN = 1'b1;
        tick();

        // Write then read back 0x1010
        do_write(16'h1010, 8'hA5, 1'b0);
        tick();
        do_read(16'h1010, 8'hA5, 1'b0);

        // Last valid location and a second known byte
        do_write(16'h10FF, 8'h5A, 1'b0);
        do_read(16'h10FF, 8'h5A, 1'b0);
        do_write(16'h1000, 8'h11, 1'b0);

        // Wrong ID and out-of-range address are ignored
        send_addr(16'h2010, 1'b1, 16);
        aack(1'b0);
        tick();
        send_addr(16'h1100, 1'b1, 16);
        aack(1'b0);
        tick();
        send_addr(16'h2010, 1'b0, 16);
        aack(1'b0);
        tick();
        do_read(16'h1010, 8'hA5, 1'b0);
        do_read(16'h1000, 8'h11, 1'b0);

        // Read paused for 3 cycles after bit 3, then resent from bit 0
        do_write(16'h1020, 8'h3C, 1'b0);
        send_addr(16'h1020, 1'b0, 16);
        aack(1'b1);
        check("pause_start", S_BUS_OUT, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("pause_pre_bit", S_BUS_OUT, (8'h3C >> i) & 8'h01);
        end
        B_UTIL = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pause_bout", S_BUS_OUT, 0);
            check("pause_bsy", S_BSY, 1);
        end
        B_UTIL = 1'b1;
        rphase(8'h3C, 1'b0);

        // Write aborted at data bit 4 leaves memory untouched
        send_addr(16'h1010, 1'b1, 16);
        aack(1'b1);
        for (int i = 0; i < 4; i++) begin
            B_BUS_IN = 1'b1;
            tick();
        end
        B_UTIL = 1'b0;
        tick();
        check("wabort_bsy", S_BSY, 0);
        check("wabort_ack", S_ACK, 0);
        do_read(16'h1010, 8'hA5, 1'b0);

        // Reset during address bit 9, then a full write succeeds
        send_addr(16'h1030, 1'b1, 9);
        RSTN   = 1'b0;
        B_UTIL = 1'b0;
        #1;
        check("rst_addr_bsy", S_BSY, 0);
        check("rst_addr_ack", S_ACK, 0);
        check("rst_addr_bout", S_BUS_OUT, 0);
        tick();
        RSTN = 1'b1;
        tick();
        do_write(16'h1030, 8'h96, 1'b0);
        do_read(16'h1030, 8'h96, 1'b0);

        // Reset in first WACK cycle discards the pending write
        send_addr(16'h1010, 1'b1, 16);
        aack(1'b1);
        for (int i = 0; i < 8; i++) begin
            B_BUS_IN = 1'b0;
            tick();
        end
        check("rst_wack_pre_ack", S_ACK, 1);
        RSTN   = 1'b0;
        B_UTIL = 1'b0;
        #1;
        check("rst_wack_ack", S_ACK, 0);
        check("rst_wack_bsy", S_BSY, 0);
        tick();
        RSTN = 1'b1;
        tick();
        do_read(16'h1010, 8'hA5, 1'b0);

        // Back-to-back frames with no idle bubble
        do_write(16'h1040, 8'hC3, 1'b1);
        do_read(16'h1040, 8'hC3, 1'b1);
        do_read(16'h10FF, 8'h5A, 1'b0);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
